// File: rtl/note_sequencer.sv
// note_sequencer: buffers {tone, vol, dur} notes in a FIFO and plays them
// one after another to a tone generator, counting each note's length in
// ticks of TICK_DIV clock cycles.
// Optional feature: define NOTE_SEQ_GAP_EN to insert GAP_TICKS silent ticks
// after every played note (GAP state). Without it, notes are separated only
// by the single LOAD cycle.
module note_sequencer #(
    parameter int TICK_DIV   = 1000000,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_TICKS  = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WR_EN,
    input  logic [5:0] WR_TONE,
    input  logic [3:0] WR_VOL,
    input  logic [7:0] WR_DUR,
    input  logic       START,
    input  logic       STOP,
    output logic [5:0] TONE,
    output logic [3:0] VOL,
    output logic       BUSY,
    output logic       FULL,
    output logic       EMPTY,
    output logic       NOTE_DONE,
    output logic       OVF
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [23:0]   PRESC_LAST = 24'(TICK_DIV - 1);
    localparam logic [23:0]   PRESC_NEAR = 24'(TICK_DIV - 2);

    // Reject out-of-range configurations at elaboration time
    if (TICK_DIV < 2 || TICK_DIV > 16777215) begin : g_bad_tick_div
        $error("note_sequencer: TICK_DIV out of range");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("note_sequencer: FIFO_DEPTH must be a power of two in 2..64");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap
        $error("note_sequencer: GAP_TICKS out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
`ifdef NOTE_SEQ_GAP_EN
        , GAP = 2'd3
`endif
    } state_t;

    state_t state, state_next;

    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CW-1:0] count, count_next;
    logic          push, pop;
    logic [5:0]    head_tone;
    logic [3:0]    head_vol;
    logic [7:0]    head_dur, peek_dur;

    logic [23:0]   presc;
    logic [7:0]    rem;
    logic          seg_end;

    logic [5:0]    tone_next;
    logic [3:0]    vol_next;
    logic          done_next;

    assign {head_tone, head_vol, head_dur} = mem[rd_ptr];
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign push       = WR_EN && (count != DEPTH_C);
    assign pop        = (state == LOAD) && !STOP;
    assign count_next = count + CW'(push) - CW'(pop);
    assign seg_end    = (rem == 8'd1) && (presc == PRESC_LAST);

    // Duration of the entry that will sit at the FIFO head next cycle,
    // bypassing the write port when that entry is being written right now
    always_comb begin
        peek_dur = head_dur;
        if (pop) begin
            peek_dur = (count == CW'(1)) ? WR_DUR : mem[rd_ptr_inc][7:0];
        end else if (count == '0) begin
            peek_dur = WR_DUR;
        end
    end

    // Note storage; data only, not reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {WR_TONE, WR_VOL, WR_DUR};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            count <= count_next;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic; STOP overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (START && count != '0) state_next = LOAD;
            LOAD: begin
                if (head_dur == 8'd0) state_next = (count_next != '0) ? LOAD : IDLE;
                else                  state_next = PLAY;
            end
            PLAY: begin
`ifdef NOTE_SEQ_GAP_EN
                if (seg_end) state_next = GAP;
`else
                if (seg_end) state_next = (count_next != '0) ? LOAD : IDLE;
`endif
            end
`ifdef NOTE_SEQ_GAP_EN
            GAP:  if (seg_end) state_next = (count_next != '0) ? LOAD : IDLE;
`endif
            default: state_next = IDLE;
        endcase
        if (STOP) state_next = IDLE;
    end

    // Tick prescaler and remaining-tick counter for PLAY and GAP
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc <= '0;
            rem   <= '0;
        end else if (state == LOAD && state_next == PLAY) begin
            presc <= '0;
            rem   <= head_dur;
`ifdef NOTE_SEQ_GAP_EN
        end else if (state == PLAY && state_next == GAP) begin
            presc <= '0;
            rem   <= 8'(GAP_TICKS);
`endif
        end else if (state_next == state && state != IDLE && state != LOAD) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                rem   <= rem - 8'd1;
            end else begin
                presc <= presc + 24'd1;
            end
        end
    end

    // FSM output logic: values the output registers take next cycle
    always_comb begin
        tone_next = '0;
        vol_next  = '0;
        if (state_next == PLAY) begin
            if (state == LOAD) begin
                tone_next = head_tone;
                vol_next  = head_vol;
            end else begin
                tone_next = TONE;
                vol_next  = VOL;
            end
        end
        // Pulse lands on the last PLAY cycle, or on the LOAD of a skipped note
        done_next = ((state == PLAY) && (state_next == PLAY) &&
                     (rem == 8'd1) && (presc == PRESC_NEAR)) ||
                    ((state_next == LOAD) && (peek_dur == 8'd0));
    end

    // Output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            TONE      <= '0;
            VOL       <= '0;
            BUSY      <= 1'b0;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            NOTE_DONE <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            TONE      <= tone_next;
            VOL       <= vol_next;
            BUSY      <= (state_next != IDLE);
            FULL      <= (count_next == DEPTH_C);
            EMPTY     <= (count_next == '0);
            NOTE_DONE <= done_next;
            OVF       <= OVF || (WR_EN && count == DEPTH_C);
        end
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000000, CLK cycles per duration tick (10 ms at 100 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter FIFO_DEPTH, default 16, note-buffer entries; power of two, 2 to 64.
REQ-003 Parameter GAP_TICKS, default 1, silent ticks between notes; legal range 1 to 255; used only when NOTE_SEQ_GAP_EN is defined.
REQ-004 CLK  in  1  100 MHz clock; sole clock.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 WR_EN  in  1  push one note into the FIFO.
REQ-007 WR_TONE  in  6  tone code of pushed note; 0 = rest.
REQ-008 WR_VOL  in  4  volume of pushed note.
REQ-009 WR_DUR  in  8  note length in ticks; 0 = skip note.
REQ-010 START  in  1  begin or resume playback.
REQ-011 STOP  in  1  abort playback.
REQ-012 TONE  out  6  tone code to the tone generator.
REQ-013 VOL  out  4  volume to the tone generator.
REQ-014 BUSY  out  1  high in any state other than IDLE.
REQ-015 FULL  out  1  FIFO holds FIFO_DEPTH entries.
REQ-016 EMPTY  out  1  FIFO holds 0 entries.
REQ-017 NOTE_DONE  out  1  one-cycle pulse when a note retires.
REQ-018 OVF  out  1  sticky flag: a write was dropped.

Function
REQ-019 All outputs SHALL be registered; FIFO entry = {tone, vol, dur}, 18 bits.
REQ-020 FSM states SHALL be IDLE, LOAD, PLAY, GAP; TONE=0 and VOL=0 in every state except PLAY.
REQ-021 IDLE: START with EMPTY=0 -> LOAD next cycle; START with EMPTY=1 -> remain in IDLE, no other effect.
REQ-022 LOAD: pop head into note registers in one cycle; DUR=0 -> pulse NOTE_DONE, then LOAD if FIFO is still non-empty after the pop, else IDLE; DUR>0 -> PLAY.
REQ-023 PLAY: drive the latched TONE/VOL; prescaler cleared on entry; remaining count decrements once every TICK_DIV cycles.
REQ-024 PLAY SHALL last exactly DUR*TICK_DIV cycles; on the final cycle pulse NOTE_DONE, then go to GAP (macro defined) or LOAD/IDLE depending on EMPTY.
REQ-025 Latency: START sampled at cycle n in IDLE -> TONE/VOL valid from cycle n+2.
REQ-026 WR_EN while FULL=1 SHALL drop the write and set OVF, even when a pop occurs in the same cycle.
REQ-027 A write and a pop in the same cycle with the FIFO neither full nor empty SHALL both succeed; occupancy unchanged.
REQ-028 A write while EMPTY=1 SHALL be readable by a LOAD no earlier than the following cycle.
REQ-029 STOP SHALL force IDLE on the next cycle from any state; outputs go to zero; remaining note discarded; FIFO contents kept; no NOTE_DONE pulse.
REQ-030 START and STOP asserted together: STOP wins.
REQ-031 START while BUSY=1 SHALL be ignored.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FULL and EMPTY SHALL reflect occupancy after the current cycle's operations.

Reset
REQ-033 RST_N=0 at a CLK edge SHALL force the following state: IDLE; TONE=0; VOL=0; BUSY=0; NOTE_DONE=0; OVF=0; FIFO emptied (EMPTY=1, FULL=0); prescaler cleared; note counter cleared.
REQ-034 Reset asserted mid-note SHALL silence the outputs on the next cycle; no NOTE_DONE pulse.

Configuration
REQ-035 Macro NOTE_SEQ_GAP_EN defined: after each played note, the FSM SHALL hold GAP for GAP_TICKS*TICK_DIV cycles with TONE=0 and VOL=0, then go to LOAD or IDLE; STOP aborts GAP.
REQ-036 Macro undefined: the GAP state and GAP_TICKS logic SHALL be absent; notes play back-to-back with the single LOAD cycle of silence between them.

Verification (TICK_DIV=4, FIFO_DEPTH=4, GAP_TICKS=1)
REQ-037 Push {5,8,3}, START at cycle 10 -> TONE=5 and VOL=8 for cycles 12-23, NOTE_DONE at cycle 23, then IDLE with BUSY=0.
REQ-038 Push 5 notes back-to-back -> FULL after the 4th push, 5th write dropped, OVF=1; playback emits exactly 4 NOTE_DONE pulses.
REQ-039 Push {7,15,0} then {9,4,1}, START -> NOTE_DONE pulse in the skip LOAD, then TONE=9 for 4 cycles.
REQ-040 Mid-note STOP together with START -> next cycle IDLE, TONE=0, VOL=0, remaining FIFO entries intact; a later START plays the next entry.
REQ-041 Two notes played, macro defined -> 4 silent GAP cycles plus 1 LOAD cycle between notes; macro undefined -> 1 silent LOAD cycle.
REQ-042 RST_N=0 during PLAY with 2 entries queued -> outputs zero next cycle, EMPTY=1, OVF=0, START has no effect afterwards.
